// File: rtl/fpga_to_host_mem.sv
// rtl/fpga_to_host_mem.sv - Manta bus core exposing a user-written memory and write counter to the host
module fpga_to_host_mem #(
  parameter logic [15:0] BASE_ADDR       = 16'h0000,
  parameter int          DEPTH           = 256,
  parameter int          WIDTH           = 8,
  parameter int          USER_ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                addr_i,
  input  logic [15:0]                data_i,
  input  logic                       rw_i,
  input  logic                       valid_i,
  output logic [15:0]                addr_o,
  output logic [15:0]                data_o,
  output logic                       rw_o,
  output logic                       valid_o,
  input  logic [USER_ADDR_WIDTH-1:0] user_addr,
  input  logic [WIDTH-1:0]           user_data_in,
  input  logic                       user_we
);

  logic [15:0]                rel_addr;
  logic [USER_ADDR_WIDTH-1:0] rd_idx;
  logic                       is_mem;
  logic                       is_cnt;
  logic                       cnt_clear;

  logic [WIDTH-1:0]           mem [DEPTH];
  logic [WIDTH-1:0]           rd_s1;

  logic [15:0]                addr_s1;
  logic [15:0]                data_s1;
  logic                       rw_s1;
  logic                       valid_s1;
  logic                       mem_rd_s1;
  logic                       cnt_rd_s1;
  logic [15:0]                cnt_s1;

  logic [15:0]                write_count;
  logic [15:0]                data_next;

  // Address decode relative to the core base; addresses below the base wrap high and fall out as foreign.
  always_comb begin
    rel_addr  = addr_i - BASE_ADDR;
    rd_idx    = rel_addr[USER_ADDR_WIDTH-1:0];
    is_mem    = ({1'b0, rel_addr} < 17'(DEPTH));
    is_cnt    = ({1'b0, rel_addr} == 17'(DEPTH));
    cnt_clear = valid_i && rw_i && is_cnt;
  end

  // User write port and synchronous bus read; non-blocking semantics give read-first on a collision.
  always_ff @(posedge clk) begin
    if (user_we) begin
      mem[user_addr] <= user_data_in;
    end
    rd_s1 <= mem[rd_idx];
  end

  // Stage 1: capture the transaction, decode result and the pre-clear counter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_s1   <= '0;
      data_s1   <= '0;
      rw_s1     <= 1'b0;
      valid_s1  <= 1'b0;
      mem_rd_s1 <= 1'b0;
      cnt_rd_s1 <= 1'b0;
      cnt_s1    <= '0;
    end else begin
      addr_s1   <= addr_i;
      data_s1   <= data_i;
      rw_s1     <= rw_i;
      valid_s1  <= valid_i;
      mem_rd_s1 <= valid_i && !rw_i && is_mem;
      cnt_rd_s1 <= valid_i && !rw_i && is_cnt;
      cnt_s1    <= write_count;
    end
  end

  // Saturating user-write counter; a bus clear wins but still counts a coincident user write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_count <= '0;
    end else if (cnt_clear) begin
      write_count <= user_we ? 16'd1 : 16'd0;
    end else if (user_we && (write_count != 16'hFFFF)) begin
      write_count <= write_count + 16'd1;
    end
  end

  // Select the read data for our reads, otherwise pass the upstream data through.
  always_comb begin
    data_next = data_s1;
    if (mem_rd_s1) begin
      data_next = 16'(rd_s1);
    end else if (cnt_rd_s1) begin
      data_next = cnt_s1;
    end
  end

  // Stage 2: output register toward the downstream core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_o  <= '0;
      data_o  <= '0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      addr_o  <= addr_s1;
      data_o  <= data_next;
      rw_o    <= rw_s1;
      valid_o <= valid_s1;
    end
  end

endmodule
